down_counter: RTL and testbench



---
 rtl/down_counter.sv | 100 ++++++++++
 tb/tb_down_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable, cascadable N-bit down counter with borrow chain and a one-shot countdown FSM.
// Define DOWN_COUNTER_RELOAD_EN to add a reload register for periodic done pulses.
module down_counter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         bin,
    output logic [N-1:0] q,
    output logic         bout,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] One = N'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [N-1:0] wrap_val;
    logic         rearm;

`ifdef DOWN_COUNTER_RELOAD_EN
    logic [N-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= d;
        end
    end

    assign wrap_val = reload_q;
    assign rearm    = (reload_q != '0);
`else
    assign wrap_val = '1;
    assign rearm    = 1'b0;
`endif

    // Combinational borrow so a chain of slices steps as one wide counter per cycle.
    assign bout = (cnt_q == '0) && bin;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = d;
        end else if (bin) begin
            cnt_d = (cnt_q == '0) ? wrap_val : cnt_q - One;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (d != '0) ? StRun : StDone;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StRun: begin
                    if (bin && (cnt_q == One)) begin
                        state_d = StDone;
                    end
                end
                StDone:  state_d = rearm ? StRun : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Flags are registered from the next state so they line up with state_q.
    always_comb begin
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    assign q    = cnt_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter; a second slice chained on bout
// exercises the borrow cascade.
module tb_down_counter;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] d;
    logic       bin;
    logic [3:0] q;
    logic       bout;
    logic       busy;
    logic       done;

    logic [3:0] q_hi;
    logic       bout_hi;
    logic       busy_hi;
    logic       done_hi;

    int n_checks;
    int n_fail;

`ifdef DOWN_COUNTER_RELOAD_EN
    localparam bit Reload = 1'b1;
`else
    localparam bit Reload = 1'b0;
`endif

    down_counter #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d     (d),
        .bin   (bin),
        .q     (q),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    down_counter #(.N(4)) u_hi (
        .clk   (clk),
        .reset (reset),
        .load  (1'b0),
        .d     (4'h0),
        .bin   (bout),
        .q     (q_hi),
        .bout  (bout_hi),
        .busy  (busy_hi),
        .done  (done_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_st(input string tag, input logic [3:0] eq, input logic eb,
                            input logic ed);
        check_eq({tag, ".q"}, 32'(q), 32'(eq));
        check_eq({tag, ".busy"}, 32'(busy), 32'(eb));
        check_eq({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        load     = 1'b1;
        d        = 4'hA;
        bin      = 1'b1;

        // Reset beats load and bin.
        tick();
        check_st("rst1", 4'h0, 1'b0, 1'b0);
        check_eq("rst1.bout", 32'(bout), 32'd1);
        tick();
        check_st("rst2", 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        load  = 1'b0;
        bin   = 1'b0;
        #1;
        check_eq("idle.bout", 32'(bout), 32'd0);

        // One-shot countdown from 3.
        load = 1'b1;
        d    = 4'h3;
        bin  = 1'b1;
        tick();
        check_st("os3", 4'h3, 1'b1, 1'b0);
        load = 1'b0;
        tick();
        check_st("os2", 4'h2, 1'b1, 1'b0);
        tick();
        check_st("os1", 4'h1, 1'b1, 1'b0);
        tick();
        check_st("os0", 4'h0, 1'b0, 1'b1);
        tick();
        if (Reload) check_st("os_after", 4'h3, 1'b1, 1'b0);
        else        check_st("os_after", 4'hF, 1'b0, 1'b0);
        bin = 1'b0;
        tick();
        if (Reload) check_st("os_hold", 4'h3, 1'b1, 1'b0);
        else        check_st("os_hold", 4'hF, 1'b0, 1'b0);

        // Load wins over bin mid-run.
        load = 1'b1;
        d    = 4'h7;
        bin  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        check_st("pri_pre", 4'h5, 1'b1, 1'b0);
        load = 1'b1;
        d    = 4'h9;
        #1;
        check_eq("pri.bout", 32'(bout), 32'd0);
        tick();
        check_st("pri_load", 4'h9, 1'b1, 1'b0);
        load = 1'b0;
        bin  = 1'b0;
        tick();
        check_st("pri_stay", 4'h9, 1'b1, 1'b0);

        // Load zero: immediate done, never busy.
        load = 1'b1;
        d    = 4'h0;
        tick();
        check_st("lz", 4'h0, 1'b0, 1'b1);
        load = 1'b0;
        tick();
        check_st("lz_after", 4'h0, 1'b0, 1'b0);

        // Reset mid-run drops the count with no done.
        load = 1'b1;
        d    = 4'h6;
        tick();
        check_st("mr6", 4'h6, 1'b1, 1'b0);
        load = 1'b0;
        bin  = 1'b1;
        tick();
        tick();
        check_st("mr4", 4'h4, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        check_st("mr_rst", 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        bin   = 1'b0;
        tick();
        check_st("mr_idle", 4'h0, 1'b0, 1'b0);

        // Two-slice cascade: 8-bit 0 steps to FF, then FE.
        check_eq("cas.hi0", 32'(q_hi), 32'h0);
        bin = 1'b1;
        #1;
        check_eq("cas.bout_lo", 32'(bout), 32'd1);
        check_eq("cas.bout_hi", 32'(bout_hi), 32'd1);
        tick();
        if (Reload) check_eq("cas.wide1", 32'({q_hi, q}), 32'h00);
        else        check_eq("cas.wide1", 32'({q_hi, q}), 32'hFF);
        tick();
        if (Reload) check_eq("cas.wide2", 32'({q_hi, q}), 32'h00);
        else        check_eq("cas.wide2", 32'({q_hi, q}), 32'hFE);
        check_eq("cas.idle_done", 32'(done), 32'd0);
        check_eq("cas.idle_busy", 32'(busy), 32'd0);
        bin = 1'b0;

`ifdef DOWN_COUNTER_RELOAD_EN
        // Periodic: 2,1,0,2,1,0 with done on each 0.
        load = 1'b1;
        d    = 4'h2;
        bin  = 1'b1;
        tick();
        check_st("rl0", 4'h2, 1'b1, 1'b0);
        load = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            case (i % 3)
                1:       check_st($sformatf("rl%0d", i), 4'h1, 1'b1, 1'b0);
                2:       check_st($sformatf("rl%0d", i), 4'h0, 1'b0, 1'b1);
                default: check_st($sformatf("rl%0d", i), 4'h2, 1'b1, 1'b0);
            endcase
        end
        bin = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
